pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised fetch-stage program counter. It holds the current fetch address and selects the next address: sequential increment, jump redirect from ID, branch-mispredict redirect from EX, or trap redirect from the exception logic. It adds a proper active-high stall, an instruction-memory ready handshake and a pending-redirect register, so a redirect that arrives during a stall is not lost. It also flags misaligned targets. It sits between the hazard unit, the branch/jump resolution logic and the instruction memory interface.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
INC_BYTES, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low address bits that must be zero for a legal target

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall_i  in  1  hazard hold; 1 = PC must not change
imem_ready_i  in  1  instruction memory accepted the current fetch address
jmp_valid_i  in  1  ID-stage jump redirect request
jmp_target_i  in  XLEN  jump target
br_valid_i  in  1  EX-stage branch mispredict redirect request
br_target_i  in  XLEN  branch target
trap_valid_i  in  1  trap/exception redirect request
trap_target_i  in  XLEN  trap vector
pc_o  out  XLEN  current fetch address
pc_plus_o  out  XLEN  pc_o + INC_BYTES, combinational
fetch_valid_o  out  1  pc_o is a valid fetch request
redirect_pending_o  out  1  a redirect is latched and waiting
misalign_o  out  1  one-cycle pulse: a rejected misaligned jmp/br target

Behaviour:
- Reset is synchronous: while rst_n=0 at a clk edge, the following values load:
  - pc_o=RESET_VECTOR, fetch_valid_o=0, pending register cleared, misalign_o=0.
- fetch_valid_o goes to 1 on the first edge with rst_n=1 and stays 1 thereafter. pc_o is not changed on that edge.
- Priority rank: trap(3) > br(2) > jmp(1). The effective redirect is the highest-ranked of the incoming valid requests and the pending entry.
- Trap targets are always accepted; their low ALIGN_BITS are forced to 0.
- jmp/br targets with nonzero low ALIGN_BITS are rejected:
  - misalign_o=1 for the next cycle.
  - The request is not applied or latched.
  - A simultaneous lower-ranked legal request is still considered.
- Next-PC rules at each edge (rst_n=1), evaluated in order:
  1. stall_i=1: pc_o holds. Any incoming legal redirect whose rank is >= the pending rank overwrites the pending entry (target and rank). redirect_pending_o=1.
  2. stall_i=0 and an effective redirect exists: pc_o <= effective target. The pending entry is cleared. imem_ready_i is ignored, because the redirect cancels the outstanding fetch.
  3. stall_i=0, no redirect, imem_ready_i=1: pc_o <= pc_o + INC_BYTES.
  4. Otherwise: pc_o holds.
- Increment arithmetic is modulo 2^XLEN. From 0xFFFF_FFFC with XLEN=32 and INC_BYTES=4, the next value is 0x0000_0000. No flag is raised on wrap.
- redirect_pending_o is driven directly from the pending-valid register.
- Latency: a redirect presented with stall_i=0 appears on pc_o after 1 edge. A latched redirect appears 1 edge after stall_i falls.
- Requests are level-sampled each cycle. A source that holds valid for N cycles is treated as N requests; overwrite follows the rank rule.

Decomposition:
- Shared package (pipeline pkg): redirect rank encoding (RANK_NONE=0, JMP=1, BR=2, TRAP=3) and a redirect_t struct {valid, rank, target[XLEN-1:0]}.
- One sub-module is natural: redirect_arbiter. It is combinational and takes the three requests plus the pending entry. It outputs the effective redirect and the misalign flags.
- The PC and pending registers stay in pc_unit.

Test Plan:
- Reset then run, with imem_ready_i=1 and no stalls: pc_o = 0x0, 0x0, 0x4, 0x8, 0xC. fetch_valid_o rises after the first post-reset edge.
- imem_ready_i=0 for 3 cycles at pc_o=0x10: pc_o holds 0x10. It becomes 0x14 one edge after ready returns.
- stall_i=1 for 4 cycles:
  - br_valid_i pulses with 0x200 in cycle 1; jmp_valid_i pulses with 0x300 in cycle 2.
  - Required: pending keeps 0x200 (higher rank) and redirect_pending_o=1.
  - pc_o=0x200 one edge after stall_i falls; pending then clears.
- Same cycle, stall_i=0: jmp 0x100, br 0x200, trap 0x8000_0003 -> pc_o=0x8000_0000 (trap wins, low bits masked).
- jmp_target_i=0x102 with no other request: pc_o continues sequentially and misalign_o pulses for exactly 1 cycle. Separately, jmp 0x102 with br 0x400 in the same cycle -> pc_o=0x400, misalign_o=1.
- pc_o=0xFFFF_FFFC with ready=1 -> 0x0000_0000. Reset asserted while a redirect is pending -> pc_o=RESET_VECTOR and redirect_pending_o=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage types: redirect rank encoding and the redirect record
// passed between the arbiter and the PC/pending registers.
package pc_unit_pkg;

  // Width of the redirect record's target field; pc_unit's XLEN must match.
  localparam int PC_XLEN = 32;

  typedef enum logic [1:0] {
    RANK_NONE = 2'd0,
    RANK_JMP  = 2'd1,
    RANK_BR   = 2'd2,
    RANK_TRAP = 2'd3
  } rank_e;

  typedef struct packed {
    logic               valid;
    rank_e              rank;
    logic [PC_XLEN-1:0] target;
  } redirect_t;

endpackage

// File: rtl/pc_unit_redirect_arbiter.sv
// Combinational redirect selection: filters misaligned jmp/br targets, picks
// the best incoming request and arbitrates it against the pending entry.
module pc_unit_redirect_arbiter
  import pc_unit_pkg::*;
#(
  parameter int XLEN       = PC_XLEN,
  parameter int ALIGN_BITS = 2
) (
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  redirect_t       pending,
  output redirect_t       incoming,
  output redirect_t       effective,
  output logic            jmp_misalign,
  output logic            br_misalign
);

  localparam logic [XLEN-1:0] LOW_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

  always_comb begin
    jmp_misalign = jmp_valid && |(jmp_target & LOW_MASK);
    br_misalign  = br_valid  && |(br_target  & LOW_MASK);

    incoming = '0;
    if (trap_valid)
      incoming = '{valid: 1'b1, rank: RANK_TRAP, target: trap_target & ~LOW_MASK};
    else if (br_valid && !br_misalign)
      incoming = '{valid: 1'b1, rank: RANK_BR, target: br_target};
    else if (jmp_valid && !jmp_misalign)
      incoming = '{valid: 1'b1, rank: RANK_JMP, target: jmp_target};

    // An empty pending entry carries RANK_NONE, so any valid request wins;
    // on equal rank the newer request replaces the latched one.
    effective = pending;
    if (incoming.valid && incoming.rank >= pending.rank)
      effective = incoming;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, imem ready handshake and a pending
// redirect register so redirects arriving under stall are applied afterwards.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC_BYTES    = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            imem_ready_i,
  input  logic            jmp_valid_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            fetch_valid_o,
  output logic            redirect_pending_o,
  output logic            misalign_o
);

  redirect_t pending;
  redirect_t incoming;
  redirect_t effective;
  logic      jmp_misalign;
  logic      br_misalign;

  pc_unit_redirect_arbiter #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_arb (
    .jmp_valid    (jmp_valid_i),
    .jmp_target   (jmp_target_i),
    .br_valid     (br_valid_i),
    .br_target    (br_target_i),
    .trap_valid   (trap_valid_i),
    .trap_target  (trap_target_i),
    .pending      (pending),
    .incoming     (incoming),
    .effective    (effective),
    .jmp_misalign (jmp_misalign),
    .br_misalign  (br_misalign)
  );

  assign pc_plus_o          = pc_o + XLEN'(INC_BYTES);
  assign redirect_pending_o = pending.valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_o          <= RESET_VECTOR;
      fetch_valid_o <= 1'b0;
      pending       <= '0;
      misalign_o    <= 1'b0;
    end else begin
      misalign_o <= jmp_misalign | br_misalign;
      // First edge out of reset only raises fetch_valid; the PC stays put.
      if (!fetch_valid_o) begin
        fetch_valid_o <= 1'b1;
      end else if (stall_i) begin
        if (incoming.valid && incoming.rank >= pending.rank)
          pending <= incoming;
      end else if (effective.valid) begin
        // Redirect cancels the outstanding fetch, so imem_ready_i is moot.
        pc_o    <= effective.target;
        pending <= '0;
      end else if (imem_ready_i) begin
        pc_o <= pc_plus_o;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed + randomized bench for pc_unit against a rule-level reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, ready = 1'b0;
  logic        jv = 1'b0, bv = 1'b0, tv = 1'b0;
  logic [31:0] jt = '0, bt = '0, tt = '0;
  logic [31:0] pc, pc_plus;
  logic        fv, pend, mis;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc = '0;
  logic [31:0] m_tgt = '0;
  bit          m_fv = 0, m_pend = 0, m_mis = 0;
  int          m_rank = 0;

  pc_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_i            (stall),
    .imem_ready_i       (ready),
    .jmp_valid_i        (jv),
    .jmp_target_i       (jt),
    .br_valid_i         (bv),
    .br_target_i        (bt),
    .trap_valid_i       (tv),
    .trap_target_i      (tt),
    .pc_o               (pc),
    .pc_plus_o          (pc_plus),
    .fetch_valid_o      (fv),
    .redirect_pending_o (pend),
    .misalign_o         (mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next state from the written rules, using the inputs present before the edge.
  task automatic model_next();
    int          best;
    logic [31:0] best_t;
    if (!rst_n) begin
      m_pc = 32'h0; m_fv = 0; m_pend = 0; m_rank = 0; m_mis = 0;
      return;
    end
    m_mis = (jv && (jt % 4) != 0) || (bv && (bt % 4) != 0);
    if (!m_fv) begin
      m_fv = 1;
      return;
    end
    best = 0; best_t = '0;
    if (jv && (jt % 4) == 0) begin best = 1; best_t = jt; end
    if (bv && (bt % 4) == 0) begin best = 2; best_t = bt; end
    if (tv)                  begin best = 3; best_t = tt - (tt % 4); end
    if (stall) begin
      if (best != 0 && best >= m_rank) begin
        m_pend = 1; m_rank = best; m_tgt = best_t;
      end
    end else if (best != 0 && best >= m_rank) begin
      m_pc = best_t; m_pend = 0; m_rank = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0; m_rank = 0;
    end else if (ready) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("fetch_valid", {31'b0, fv}, {31'b0, m_fv});
    chk("pending", {31'b0, pend}, {31'b0, m_pend});
    chk("misalign", {31'b0, mis}, {31'b0, m_mis});
  endtask

  task automatic clr_req();
    jv = 0; bv = 0; tv = 0;
  endtask

  initial begin
    // reset state
    rst_n = 0; ready = 1;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'b0, fv}, 32'h0);
    chk("rst_pend", {31'b0, pend}, 32'h0);

    // sequential run: 0,0,4,8,C,10
    rst_n = 1;
    step(); chk("run0_pc", pc, 32'h0); chk("run0_fv", {31'b0, fv}, 32'h1);
    step(); chk("run1_pc", pc, 32'h4);
    step(); chk("run2_pc", pc, 32'h8);
    step(); chk("run3_pc", pc, 32'hC);
    step(); chk("run4_pc", pc, 32'h10);

    // imem not ready for 3 cycles
    ready = 0;
    repeat (3) begin step(); chk("notready_pc", pc, 32'h10); end
    ready = 1;
    step(); chk("ready_back_pc", pc, 32'h14);

    // redirects under stall: br 0x200 must survive a later jmp 0x300
    stall = 1;
    bv = 1; bt = 32'h200; step(); clr_req();
    jv = 1; jt = 32'h300; step(); clr_req();
    step(); step();
    chk("stall_pc", pc, 32'h14);
    chk("stall_pend", {31'b0, pend}, 32'h1);
    stall = 0;
    step(); chk("unstall_pc", pc, 32'h200); chk("unstall_pend", {31'b0, pend}, 32'h0);

    // simultaneous jmp/br/trap: trap wins with low bits masked
    jv = 1; jt = 32'h100; bv = 1; bt = 32'h200; tv = 1; tt = 32'h8000_0003;
    step(); clr_req();
    chk("trap_pc", pc, 32'h8000_0000);

    // misaligned jmp alone: sequential + one-cycle misalign pulse
    jv = 1; jt = 32'h102; step(); clr_req();
    chk("misj_pc", pc, 32'h8000_0004); chk("misj_flag", {31'b0, mis}, 32'h1);
    step(); chk("misj_flag_clr", {31'b0, mis}, 32'h0);

    // misaligned jmp with legal br
    jv = 1; jt = 32'h102; bv = 1; bt = 32'h400; step(); clr_req();
    chk("misjbr_pc", pc, 32'h400); chk("misjbr_flag", {31'b0, mis}, 32'h1);

    // wrap at top of address space
    tv = 1; tt = 32'hFFFF_FFFC; step(); clr_req();
    chk("wrap_pre_plus", pc_plus, 32'h0);
    step(); chk("wrap_pc", pc, 32'h0);

    // reset with a pending redirect
    stall = 1; bv = 1; bt = 32'h800; step(); clr_req();
    chk("prerst_pend", {31'b0, pend}, 32'h1);
    rst_n = 0; step();
    chk("rstpend_pc", pc, 32'h0); chk("rstpend_pend", {31'b0, pend}, 32'h0);
    rst_n = 1; stall = 0; step();

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 9) < 3);
      ready = ($urandom_range(0, 9) < 7);
      jv = ($urandom_range(0, 99) < 15);
      bv = ($urandom_range(0, 99) < 15);
      tv = ($urandom_range(0, 99) < 8);
      jt = $urandom; if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      bt = $urandom; if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      tt = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
